// File: rtl/stoch_decode_pkg.sv
// Shared types and helpers for stochastic bitstream decoders: FSM state,
// per-element count width and bipolar conversion.
package stoch_decode_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  // A window of 2^window_log2 bits can hold exactly 2^window_log2 ones, hence the extra bit.
  function automatic int count_width(input int window_log2);
    return window_log2 + 1;
  endfunction

  // 2*count - 2^window_log2 in a 32-bit two's-complement container; callers keep the low bits.
  function automatic logic [31:0] bipolar_value(input logic [31:0] count, input int window_log2);
    return (count << 1) - (32'd1 << window_log2);
  endfunction

endpackage

// File: rtl/stoch_bit_counter.sv
// Ones counter for a single stochastic bitstream element.
module stoch_bit_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  // Clear wins over enable so a window boundary restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CNT_W{1'b0}};
    end else if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (en) begin
      count <= count + {{(CNT_W-1){1'b0}}, bit_in};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/stoch_matrix_decode.sv
// Window-based decoder turning row-major stochastic bitstreams into element counts.
// Define STOCH_DECODE_BIPOLAR_EN for signed bipolar output (2*count - 2^WINDOW_LOG2).
module stoch_matrix_decode
  import stoch_decode_pkg::*;
#(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_COLS    = 2,
  parameter int WINDOW_LOG2 = 8,
  localparam int CNT_W      = count_width(WINDOW_LOG2),
`ifdef STOCH_DECODE_BIPOLAR_EN
  localparam int EL_W       = CNT_W + 1,
`else
  localparam int EL_W       = CNT_W,
`endif
  localparam int NUM_EL     = NUM_ROWS * NUM_COLS
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     in_valid,
  input  logic [NUM_EL-1:0]        Y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_EL*EL_W-1:0]   out_data,
  output logic                     busy,
  output logic                     overrun
);

  state_t                 state;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [NUM_EL*EL_W-1:0] final_data;
  logic                   accum_step;
  logic                   win_end;
  logic                   clear;

  // Counter control: stop outranks both accumulation and window completion.
  always_comb begin
    accum_step = 1'b0;
    win_end    = 1'b0;
    clear      = 1'b0;
    if (state == ACCUM) begin
      accum_step = in_valid & ~stop;
      win_end    = accum_step & (win_cnt == {WINDOW_LOG2{1'b1}});
      clear      = stop | win_end;
    end else begin
      clear      = start;
    end
  end

  for (genvar k = 0; k < NUM_EL; k++) begin : g_el
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] final_cnt;

    stoch_bit_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (CLK),
      .rst    (RST),
      .clear  (clear),
      .en     (accum_step),
      .bit_in (Y[k]),
      .count  (count)
    );

    // The closing bit is still in flight, so fold it in when capturing the result.
    assign final_cnt = count + {{(CNT_W-1){1'b0}}, Y[k]};
`ifdef STOCH_DECODE_BIPOLAR_EN
    logic [31:0] bip;
    assign bip = bipolar_value(32'(final_cnt), WINDOW_LOG2);
    assign final_data[k*EL_W +: EL_W] = bip[EL_W-1:0];
`else
    assign final_data[k*EL_W +: EL_W] = final_cnt;
`endif
  end

  // Control FSM, window counter, result register and output handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      win_cnt   <= {WINDOW_LOG2{1'b0}};
      out_data  <= {(NUM_EL*EL_W){1'b0}};
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACCUM;
            busy    <= 1'b1;
            win_cnt <= {WINDOW_LOG2{1'b0}};
          end
        end
        ACCUM: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            win_cnt <= {WINDOW_LOG2{1'b0}};
          end else if (in_valid) begin
            if (win_end) begin
              out_data  <= final_data;
              out_valid <= 1'b1;
              win_cnt   <= {WINDOW_LOG2{1'b0}};
              // A result accepted in this very cycle is not lost.
              if (out_valid && !out_ready) begin
                overrun <= 1'b1;
              end
            end else begin
              win_cnt <= win_cnt + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_matrix_decode.sv
// Self-checking bench for stoch_matrix_decode against a per-window counting model.
// Honours STOCH_DECODE_BIPOLAR_EN to match the bipolar build.
module tb_stoch_matrix_decode;

  localparam int N   = 4;
  localparam int WIN = 256;
`ifdef STOCH_DECODE_BIPOLAR_EN
  localparam int EL_W = 10;
`else
  localparam int EL_W = 9;
`endif
  localparam int DW = N * EL_W;

  logic          CLK;
  logic          RST;
  logic          start;
  logic          stop;
  logic          in_valid;
  logic [N-1:0]  Y;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_active;
  int            m_n;
  int            m_ones [N];
  bit            m_valid;
  bit            m_over;
  logic [DW-1:0] m_data;

  stoch_matrix_decode dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .stop      (stop),
    .in_valid  (in_valid),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [EL_W-1:0] elem_expect(input int c);
    int v;
`ifdef STOCH_DECODE_BIPOLAR_EN
    v = 2 * c - WIN;
`else
    v = c;
`endif
    return v[EL_W-1:0];
  endfunction

  function automatic logic [DW-1:0] pack_counts(input int c0, input int c1, input int c2, input int c3);
    logic [DW-1:0] d;
    d[0*EL_W +: EL_W] = elem_expect(c0);
    d[1*EL_W +: EL_W] = elem_expect(c1);
    d[2*EL_W +: EL_W] = elem_expect(c2);
    d[3*EL_W +: EL_W] = elem_expect(c3);
    return d;
  endfunction

  // One clock: inputs already applied, sample #1 after the edge, then advance the model.
  task automatic tick();
    bit hold;
    @(posedge CLK);
    #1;
    if (RST) begin
      m_active = 1'b0; m_n = 0; m_valid = 1'b0; m_over = 1'b0; m_data = '0;
      for (int k = 0; k < N; k++) m_ones[k] = 0;
    end else begin
      hold = m_valid && !out_ready;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1; m_n = 0;
          for (int k = 0; k < N; k++) m_ones[k] = 0;
        end
      end else if (stop) begin
        m_active = 1'b0;
      end else if (in_valid) begin
        for (int k = 0; k < N; k++) m_ones[k] += int'(Y[k]);
        m_n++;
        if (m_n == WIN) begin
          if (hold) m_over = 1'b1;
          for (int k = 0; k < N; k++) begin
            m_data[k*EL_W +: EL_W] = elem_expect(m_ones[k]);
            m_ones[k] = 0;
          end
          m_n = 0;
          hold = 1'b1;
        end
      end
      m_valid = hold;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; Y = '0; out_ready = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b1; Y = '1; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    RST = 1'b0; in_valid = 1'b0; Y = '0;
  endtask

  task automatic test_all_ones();
    bit early = 1'b0;
    do_reset();
    do_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b expected 1", busy); end
    in_valid = 1'b1; Y = '1; out_ready = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      tick();
      if (i < WIN - 1 && out_valid) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL ones_early_valid: got %b expected 0", early); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ones_latency: got out_valid %b expected 1", out_valid); end
    n_checks++; if (out_data !== pack_counts(WIN, WIN, WIN, WIN)) begin n_fail++; $display("FAIL ones_counts: got %h expected %h", out_data, pack_counts(WIN, WIN, WIN, WIN)); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ones_accept: got out_valid %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ones_stay_accum: got busy %b expected 1", busy); end
  endtask

  task automatic test_toggle();
    do_reset();
    do_start();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      Y = {3'b000, (i % 2 == 0) ? 1'b1 : 1'b0};
      tick();
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL toggle_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_data !== pack_counts(128, 0, 0, 0)) begin n_fail++; $display("FAIL toggle_counts: got %h expected %h", out_data, pack_counts(128, 0, 0, 0)); end
  endtask

  task automatic test_sparse_valid();
    bit early = 1'b0;
    do_reset();
    do_start();
    Y = '1; out_ready = 1'b1;
    for (int i = 0; i < 2 * WIN - 1; i++) begin
      in_valid = (i % 2 == 0);
      Y = in_valid ? 4'hF : N'($urandom);
      tick();
      if (i < 2 * WIN - 2 && out_valid) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL sparse_early_valid: got %b expected 0", early); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sparse_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_data !== pack_counts(WIN, WIN, WIN, WIN)) begin n_fail++; $display("FAIL sparse_counts: got %h expected %h", out_data, pack_counts(WIN, WIN, WIN, WIN)); end
  endtask

  task automatic test_overrun();
    bit moved = 1'b0;
    logic [DW-1:0] first;
    do_reset();
    do_start();
    in_valid = 1'b1; Y = '1; out_ready = 1'b0;
    for (int i = 0; i < WIN; i++) tick();
    first = m_data;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first_window: got %b expected 0", overrun); end
    for (int i = 0; i < WIN; i++) begin
      Y = N'($urandom);
      tick();
      if (i < WIN - 1 && out_data !== first) moved = 1'b1;
    end
    n_checks++; if (moved !== 1'b0) begin n_fail++; $display("FAIL ovr_data_stable: got %b expected 0", moved); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    n_checks++; if (out_data !== m_data) begin n_fail++; $display("FAIL ovr_second_data: got %h expected %h", out_data, m_data); end
    // Accept in the completion cycle: no overrun, new data stays valid.
    do_reset();
    do_start();
    in_valid = 1'b1; Y = '1; out_ready = 1'b0;
    for (int i = 0; i < WIN; i++) tick();
    Y = 4'b0101;
    for (int i = 0; i < WIN; i++) begin
      out_ready = (i == WIN - 1);
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ready_at_end: got %b expected 0", overrun); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b expected 1", out_valid); end
    n_checks++; if (out_data !== pack_counts(WIN, 0, WIN, 0)) begin n_fail++; $display("FAIL ovr_new_data: got %h expected %h", out_data, pack_counts(WIN, 0, WIN, 0)); end
  endtask

  task automatic test_stop();
    bit early = 1'b0;
    do_reset();
    do_start();
    in_valid = 1'b1; Y = '1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b expected 0", busy); end
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stop_no_partial: got %b expected 0", out_valid); end
    do_start();
    Y = 4'b0011;
    for (int i = 0; i < WIN; i++) begin
      tick();
      if (i < WIN - 1 && out_valid) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL stop_restart_early: got %b expected 0", early); end
    n_checks++; if (out_data !== pack_counts(WIN, WIN, 0, 0)) begin n_fail++; $display("FAIL stop_restart_counts: got %h expected %h", out_data, pack_counts(WIN, WIN, 0, 0)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start();
    in_valid = 1'b1; Y = '1; out_ready = 1'b0;
    for (int i = 0; i < WIN + 50; i++) tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending: got %b expected 1", out_valid); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rstmid_out_data: got %h expected 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 0", busy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(7) == 0);
      stop      = ($urandom_range(499) == 0);
      in_valid  = ($urandom_range(3) != 0);
      Y         = N'($urandom);
      out_ready = ($urandom_range(1) == 1);
      tick();
      n_checks++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rand_out_valid cyc %0d: got %b expected %b", i, out_valid, m_valid); end
      n_checks++; if (busy !== m_active) begin n_fail++; $display("FAIL rand_busy cyc %0d: got %b expected %b", i, busy, m_active); end
      n_checks++; if (overrun !== m_over) begin n_fail++; $display("FAIL rand_overrun cyc %0d: got %b expected %b", i, overrun, m_over); end
      n_checks++; if (out_data !== m_data) begin n_fail++; $display("FAIL rand_out_data cyc %0d: got %h expected %h", i, out_data, m_data); end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_toggle();
    test_sparse_valid();
    test_overrun();
    test_stop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
